// File: rtl/afu_user_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | afu_user_stream : input FIFO -> fixed-latency core -> output FIFO, with     |
// |                   credit-gated issue and per-job line accounting.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module afu_user_stream #(
  parameter int LINE_WIDTH     = 512,
  parameter int IN_DEPTH_BITS  = 3,
  parameter int OUT_DEPTH_BITS = 4,
  parameter int AF_MARGIN      = 4,
  parameter int AE_THRESHOLD   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LINE_WIDTH-1:0]    input_fifo_din,
  input  logic                     input_fifo_we,
  output logic                     input_fifo_full,
  output logic                     input_fifo_almost_full,
  output logic [IN_DEPTH_BITS:0]   input_fifo_count,
  output logic [LINE_WIDTH-1:0]    output_fifo_dout,
  input  logic                     output_fifo_re,
  output logic                     output_fifo_empty,
  output logic                     output_fifo_almost_empty,
  input  logic [31:0]              ctx_length,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_in_ovf,
  output logic                     err_core,
  output logic                     core_in_valid,
  output logic [LINE_WIDTH-1:0]    core_in_data,
  input  logic                     core_out_valid,
  input  logic [LINE_WIDTH-1:0]    core_out_data
);

  localparam int IN_DEPTH  = 2**IN_DEPTH_BITS;
  localparam int OUT_DEPTH = 2**OUT_DEPTH_BITS;
  localparam logic [IN_DEPTH_BITS:0]    IN_FULL_LVL = (IN_DEPTH_BITS+1)'(IN_DEPTH);
  localparam logic [IN_DEPTH_BITS:0]    AF_LVL      = (IN_DEPTH_BITS+1)'(IN_DEPTH - AF_MARGIN);
  localparam logic [OUT_DEPTH_BITS:0]   AE_LVL      = (OUT_DEPTH_BITS+1)'(AE_THRESHOLD);
  localparam logic [OUT_DEPTH_BITS+1:0] CREDIT_LIM  = (OUT_DEPTH_BITS+2)'(OUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               len, issued, written, written_nxt;
  logic [OUT_DEPTH_BITS:0]   inflight, inflight_nxt;
  logic                      start_ok, issue;

  // ---------------- input FIFO ----------------
  logic [LINE_WIDTH-1:0]     in_mem [IN_DEPTH];
  logic [IN_DEPTH_BITS-1:0]  in_wp, in_rp;
  logic [IN_DEPTH_BITS:0]    in_cnt;
  logic                      in_empty, in_push;

  assign in_empty               = (in_cnt == '0);
  assign input_fifo_full        = (in_cnt == IN_FULL_LVL);
  assign input_fifo_almost_full = (in_cnt >= AF_LVL);
  assign input_fifo_count       = in_cnt;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign in_push                = input_fifo_we && (!input_fifo_full || issue);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + 1'b1;
      if (issue)   in_rp <= in_rp + 1'b1;
      in_cnt <= in_cnt + (IN_DEPTH_BITS+1)'(in_push) - (IN_DEPTH_BITS+1)'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp] <= input_fifo_din;
  end

  // ---------------- output FIFO ----------------
  logic [LINE_WIDTH-1:0]     out_mem [OUT_DEPTH];
  logic [OUT_DEPTH_BITS-1:0] out_wp, out_rp;
  logic [OUT_DEPTH_BITS:0]   out_cnt;
  logic                      out_wr, out_rd;

  // Core results are only accepted against an outstanding credit.
  assign out_wr                   = core_out_valid && (inflight != '0);
  assign out_rd                   = output_fifo_re && !output_fifo_empty;
  assign output_fifo_empty        = (out_cnt == '0);
  assign output_fifo_almost_empty = (out_cnt <= AE_LVL);
  assign output_fifo_dout         = out_mem[out_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
    end else begin
      if (out_wr) begin
        out_mem[out_wp] <= core_out_data;
        out_wp          <= out_wp + 1'b1;
      end
      if (out_rd) out_rp <= out_rp + 1'b1;
      out_cnt <= out_cnt + (OUT_DEPTH_BITS+1)'(out_wr) - (OUT_DEPTH_BITS+1)'(out_rd);
    end
  end

  // ---------------- issue and job control ----------------
  assign issue = (state == S_RUN) && !in_empty && (issued < len) &&
                 (({1'b0, out_cnt} + {1'b0, inflight}) < CREDIT_LIM);

  assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  assign inflight_nxt = inflight + (OUT_DEPTH_BITS+1)'(issue) - (OUT_DEPTH_BITS+1)'(out_wr);
  assign written_nxt  = written + 32'(out_wr);
  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (ctx_length == '0) ? S_DONE : S_RUN;
      S_RUN:          if (issued == len) state_nxt = S_DRAIN;
      // Look at next-cycle counts so done rises with the final output write.
      S_DRAIN:        if ((inflight_nxt == '0) && (written_nxt == len)) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      len           <= '0;
      issued        <= '0;
      written       <= '0;
      inflight      <= '0;
      err_in_ovf    <= 1'b0;
      err_core      <= 1'b0;
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
    end else begin
      state         <= state_nxt;
      inflight      <= inflight_nxt;
      core_in_valid <= issue;
      if (issue) core_in_data <= in_mem[in_rp];
      if (start_ok) begin
        len     <= ctx_length;
        issued  <= '0;
        written <= '0;
      end else begin
        issued  <= issued + 32'(issue);
        written <= written_nxt;
      end
      err_in_ovf <= (err_in_ovf && !start_ok) || (input_fifo_we && input_fifo_full && !issue);
      err_core   <= (err_core && !start_ok) || (core_out_valid && (inflight == '0));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_afu_user_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_afu_user_stream : self-checking bench with a 3-cycle core model.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_afu_user_stream;

  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [LW-1:0] input_fifo_din = '0;
  logic          input_fifo_we = 1'b0;
  logic          input_fifo_full, input_fifo_almost_full;
  logic [3:0]    input_fifo_count;
  logic [LW-1:0] output_fifo_dout;
  logic          output_fifo_re = 1'b0;
  logic          output_fifo_empty, output_fifo_almost_empty;
  logic [31:0]   ctx_length = '0;
  logic          start = 1'b0;
  logic          busy, done, err_in_ovf, err_core;
  logic          core_in_valid, core_out_valid;
  logic [LW-1:0] core_in_data, core_out_data;
  logic          inj = 1'b0;
  logic [LW-1:0] inj_data = '0;

  always #5 clk = ~clk;

  afu_user_stream #(
    .LINE_WIDTH(LW), .IN_DEPTH_BITS(3), .OUT_DEPTH_BITS(4), .AF_MARGIN(4), .AE_THRESHOLD(2)
  ) dut (
    .clk(clk), .reset(reset),
    .input_fifo_din(input_fifo_din), .input_fifo_we(input_fifo_we),
    .input_fifo_full(input_fifo_full), .input_fifo_almost_full(input_fifo_almost_full),
    .input_fifo_count(input_fifo_count),
    .output_fifo_dout(output_fifo_dout), .output_fifo_re(output_fifo_re),
    .output_fifo_empty(output_fifo_empty), .output_fifo_almost_empty(output_fifo_almost_empty),
    .ctx_length(ctx_length), .start(start), .busy(busy), .done(done),
    .err_in_ovf(err_in_ovf), .err_core(err_core),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data)
  );

  // Core model: three register stages, plus a hook to inject spurious results.
  logic [2:0]    pv;
  logic [LW-1:0] pd0, pd1, pd2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0;
    end else begin
      pv <= {pv[1:0], core_in_valid};
      pd0 <= core_in_data; pd1 <= pd0; pd2 <= pd1;
    end
  end
  assign core_out_valid = pv[2] | inj;
  assign core_out_data  = inj ? inj_data : pd2;

  int            checks = 0;
  int            errors = 0;
  int            issued_seen = 0;
  logic [LW-1:0] exp_q [$];

  typedef struct {
    int len;
    int npush;
    int hold;
    int hold_exp;
    int exp_pops;
  } job_t;
  job_t jobs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (core_in_valid) issued_seen++;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic pop_compare();
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 1);
    end else begin
      chk_line("dout", output_fifo_dout, exp_q.pop_front());
    end
  endtask

  task automatic push_line();
    input_fifo_din = rand_line();
    input_fifo_we  = 1'b1;
    exp_q.push_back(input_fifo_din);
  endtask

  task automatic run_job(input bit do_start, input int len, input int npush,
                         input int hold, input int hold_exp, output int popped);
    int pushed = 0;
    int cyc = 0;
    popped = 0;
    if (do_start) begin
      issued_seen = 0;
      ctx_length = len; start = 1'b1;
      step();
      start = 1'b0;
    end
    while ((popped < len || busy) && cyc < 3000) begin
      cyc++;
      if (hold > 0 && cyc == hold) chk("hold_issued", issued_seen, hold_exp);
      if (pushed < npush && !input_fifo_full) begin
        push_line(); pushed++;
      end else input_fifo_we = 1'b0;
      if (cyc > hold && !output_fifo_empty && $urandom_range(3) != 0) begin
        pop_compare(); output_fifo_re = 1'b1; popped++;
      end else output_fifo_re = 1'b0;
      step();
    end
    input_fifo_we = 1'b0; output_fifo_re = 1'b0;
    chk("job_timeout", 32'(cyc < 3000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int popped, cyc, pushed;
    logic [LW-1:0] line_a;

    jobs[0] = '{1, 1, 0, 0, 1};
    jobs[1] = '{3, 3, 0, 0, 3};
    jobs[2] = '{8, 8, 0, 0, 8};
    jobs[3] = '{20, 20, 0, 0, 20};
    jobs[4] = '{40, 40, 60, 16, 40};   // output held off: only 16 credits available

    // Reset values
    step(); step();
    chk("rst_empty", 32'(output_fifo_empty), 1);
    chk("rst_aempty", 32'(output_fifo_almost_empty), 1);
    chk("rst_full", 32'(input_fifo_full), 0);
    chk("rst_afull", 32'(input_fifo_almost_full), 0);
    chk("rst_count", 32'(input_fifo_count), 0);
    chk_line("rst_dout", output_fifo_dout, '0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_errs", {30'd0, err_in_ovf, err_core}, 0);
    chk("rst_civ", 32'(core_in_valid), 0);
    reset = 1'b1;
    step();

    // Zero-length job completes the next cycle without issuing
    ctx_length = 0; start = 1'b1; step(); start = 1'b0;
    chk("zl_done", {30'd0, busy, done}, 1);
    step();
    chk("zl_no_issue", 32'(core_in_valid), 0);

    // Latency of a single line
    ctx_length = 1; start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", {30'd0, busy, done}, 2);
    line_a = rand_line();
    input_fifo_din = line_a; input_fifo_we = 1'b1; exp_q.push_back(line_a);
    step(); input_fifo_we = 1'b0;
    chk("t1_civ_t1", 32'(core_in_valid), 0);
    step();
    chk("t1_civ_t2", 32'(core_in_valid), 1);
    chk_line("t1_cid", core_in_data, line_a);
    step(); step(); step();
    chk("t1_empty_t5", {30'd0, output_fifo_empty, done}, 2);
    step();
    chk("t1_t6", {29'd0, output_fifo_empty, done, busy}, 2);
    pop_compare(); output_fifo_re = 1'b1; step(); output_fifo_re = 1'b0;
    chk("t1_empty_after", 32'(output_fifo_empty), 1);

    // Table-driven jobs
    foreach (jobs[k]) begin
      run_job(1'b1, jobs[k].len, jobs[k].npush, jobs[k].hold, jobs[k].hold_exp, popped);
      chk("job_pops", popped, jobs[k].exp_pops);
      chk("job_end_state", {28'd0, busy, done, err_in_ovf, err_core}, 4);
      chk("job_sb_empty", 32'(exp_q.size()), 0);
    end

    // Input FIFO fill while not running, then overflow
    for (int i = 0; i < 8; i++) begin
      push_line(); step();
      chk("fill_count", 32'(input_fifo_count), i + 1);
      chk("fill_afull", 32'(input_fifo_almost_full), 32'(i + 1 >= 4));
      chk("fill_full", 32'(input_fifo_full), 32'(i + 1 == 8));
    end
    input_fifo_din = rand_line(); input_fifo_we = 1'b1; step(); input_fifo_we = 1'b0;
    chk("ovf_err", 32'(err_in_ovf), 1);
    chk("ovf_count", 32'(input_fifo_count), 8);
    chk("ovf_held", 32'(core_in_valid), 0);
    run_job(1'b1, 8, 0, 0, 0, popped);
    chk("ovf_drain_pops", popped, 8);
    chk("ovf_err_cleared", 32'(err_in_ovf), 0);

    // Start while running is ignored
    issued_seen = 0;
    ctx_length = 2; start = 1'b1; step(); start = 1'b0;
    step();
    ctx_length = 0; start = 1'b1; step(); start = 1'b0;
    chk("busy_start_ign", {30'd0, busy, done}, 2);
    run_job(1'b0, 2, 2, 0, 0, popped);
    chk("busy_job_pops", popped, 2);
    chk("busy_job_done", 32'(done), 1);

    // Spurious core output with no credit
    inj_data = rand_line(); inj = 1'b1; step(); inj = 1'b0;
    chk("spur_err", 32'(err_core), 1);
    chk("spur_empty", 32'(output_fifo_empty), 1);
    ctx_length = 0; start = 1'b1; step(); start = 1'b0;
    chk("spur_err_clr", 32'(err_core), 0);

    // Reset in the middle of a job
    issued_seen = 0;
    ctx_length = 10; start = 1'b1; step(); start = 1'b0;
    cyc = 0; pushed = 0;
    while (issued_seen < 5 && cyc < 200) begin
      if (pushed < 10 && !input_fifo_full) begin
        push_line(); pushed++;
      end else input_fifo_we = 1'b0;
      step(); cyc++;
    end
    input_fifo_we = 1'b0;
    chk("mid_timeout", 32'(cyc < 200), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", {26'd0, output_fifo_empty, output_fifo_almost_empty,
                          input_fifo_full, input_fifo_almost_full, busy, done}, 48);
    chk("mid_rst_count", 32'(input_fifo_count), 0);
    chk("mid_rst_errs", {29'd0, err_in_ovf, err_core, core_in_valid}, 0);
    chk_line("mid_rst_dout", output_fifo_dout, '0);
    chk_line("mid_rst_cid", core_in_data, '0);
    exp_q.delete();
    step(); step();
    reset = 1'b1;
    step(); step();
    chk("post_rst_idle", {29'd0, output_fifo_empty, busy, err_core}, 4);
    run_job(1'b1, 2, 2, 0, 0, popped);
    chk("post_rst_pops", popped, 2);
    chk("post_rst_done", {30'd0, done, err_core}, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
